// File: rtl/tcdm_req_shim.sv
// Per-master request/response shim in front of the TCDM interconnect: holds requests until granted,
// limits outstanding credits and buffers responses. Optional stall statistics via TCDM_SHIM_STATS_EN.
module tcdm_req_shim #(
  parameter int unsigned AddrWidth      = 5,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 4,
  parameter bit          WriteRespOn    = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_add_i,
  input  logic                 req_wen_i,
  input  logic [DataWidth-1:0] req_wdata_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [DataWidth-1:0] resp_rdata_o,
  output logic                 req_o,
  output logic [AddrWidth-1:0] add_o,
  output logic                 wen_o,
  output logic [DataWidth-1:0] wdata_o,
  input  logic                 gnt_i,
  input  logic                 vld_i,
`ifdef TCDM_SHIM_STATS_EN
  output logic [15:0]          stall_cnt_o,
`endif
  input  logic [DataWidth-1:0] rdata_i
);

  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  logic                 pend_q, pend_d;
  logic [AddrWidth-1:0] add_q, add_d;
  logic                 wen_q, wen_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CntW-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0]      wptr_q, wptr_d;
  logic [PtrW-1:0]      rptr_q, rptr_d;
  logic [DataWidth-1:0] last_q, last_d;
  logic [DataWidth-1:0] mem_q [MaxOutstanding];
  logic [DataWidth-1:0] mem_d [MaxOutstanding];

  logic granted, load, inc, dec, push, pop, fifo_full;

  assign req_o        = pend_q & (cnt_q < MaxCnt);
  assign granted      = req_o & gnt_i;
  assign req_ready_o  = ~pend_q | granted;
  assign load         = req_valid_i & req_ready_o;
  assign add_o        = add_q;
  assign wen_o        = wen_q;
  assign wdata_o      = wdata_q;
  assign resp_valid_o = (fifo_cnt_q != '0);
  assign fifo_full    = (fifo_cnt_q == MaxCnt);
  assign pop          = resp_valid_o & resp_ready_i;
  // An overflowing push is a protocol error; dropping it keeps the FIFO count bounded.
  assign push         = vld_i & (~fifo_full | pop);
  assign inc          = granted & (~wen_q | WriteRespOn);
  assign dec          = pop & (cnt_q != '0);
  assign resp_rdata_o = resp_valid_o ? mem_q[rptr_q] : last_q;

  always_comb begin
    pend_d     = pend_q;
    add_d      = add_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    fifo_cnt_d = fifo_cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    last_d     = last_q;
    mem_d      = mem_q;

    if (load) begin
      pend_d  = 1'b1;
      add_d   = req_add_i;
      wen_d   = req_wen_i;
      wdata_d = req_wdata_i;
    end else if (granted) begin
      pend_d = 1'b0;
    end

    case ({inc, dec})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase

    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CntW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CntW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    if (push) begin
      mem_d[wptr_q] = rdata_i;
      wptr_d        = wptr_q + PtrW'(1);
    end
    if (pop) begin
      last_d = mem_q[rptr_q];
      rptr_d = rptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q     <= 1'b0;
      add_q      <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      fifo_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      last_q     <= '0;
      for (int i = 0; i < int'(MaxOutstanding); i++) mem_q[i] <= '0;
    end else begin
      pend_q     <= pend_d;
      add_q      <= add_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      last_q     <= last_d;
      mem_q      <= mem_d;
    end
  end

`ifdef TCDM_SHIM_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (req_o && !gnt_i && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

  fifo_overflow_a: assert property (@(posedge clk_i) disable iff (rst_i) !(vld_i && fifo_full && !pop));

endmodule

// File: tb/tb_tcdm_req_shim.sv
// Directed scoreboard bench for tcdm_req_shim: a default instance plus a WriteRespOn=0 instance.
module tb_tcdm_req_shim;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_valid_i, req_ready_o, req_wen_i;
  logic [AW-1:0] req_add_i;
  logic [DW-1:0] req_wdata_i;
  logic          resp_valid_o, resp_ready_i;
  logic [DW-1:0] resp_rdata_o;
  logic          req_o, wen_o, gnt_i, vld_i;
  logic [AW-1:0] add_o;
  logic [DW-1:0] wdata_o, rdata_i;

  logic          req_valid_n, req_ready_n, req_wen_n;
  logic [AW-1:0] req_add_n;
  logic [DW-1:0] req_wdata_n;
  logic          resp_valid_n, resp_ready_n;
  logic [DW-1:0] resp_rdata_n;
  logic          req_o_n, wen_o_n, gnt_n, vld_n;
  logic [AW-1:0] add_o_n;
  logic [DW-1:0] wdata_o_n, rdata_n;
`ifdef TCDM_SHIM_STATS_EN
  logic [15:0]   stall_cnt, stall_cnt_n;
`endif

  int          total = 0;
  int          bad = 0;
  int          to_send = 0;
  int          grant_cnt = 0;
  int          net_seq = 0;
  bit          net_auto = 1'b0;
  logic [31:0] exp_q [$];

  always #5 clk_i = ~clk_i;

  tcdm_req_shim #(.AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(4), .WriteRespOn(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_add_i(req_add_i),
    .req_wen_i(req_wen_i), .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_rdata_o(resp_rdata_o),
    .req_o(req_o), .add_o(add_o), .wen_o(wen_o), .wdata_o(wdata_o),
    .gnt_i(gnt_i), .vld_i(vld_i),
`ifdef TCDM_SHIM_STATS_EN
    .stall_cnt_o(stall_cnt),
`endif
    .rdata_i(rdata_i)
  );

  tcdm_req_shim #(.AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(4), .WriteRespOn(1'b0)) dut_nw (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_n), .req_ready_o(req_ready_n), .req_add_i(req_add_n),
    .req_wen_i(req_wen_n), .req_wdata_i(req_wdata_n),
    .resp_valid_o(resp_valid_n), .resp_ready_i(resp_ready_n), .resp_rdata_o(resp_rdata_n),
    .req_o(req_o_n), .add_o(add_o_n), .wen_o(wen_o_n), .wdata_o(wdata_o_n),
    .gnt_i(gnt_n), .vld_i(vld_n),
`ifdef TCDM_SHIM_STATS_EN
    .stall_cnt_o(stall_cnt_n),
`endif
    .rdata_i(rdata_n)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  // Called at the negedge: scoreboard pop, grant count, request feeder and network response model.
  task automatic apply_stimulus();
    logic        acc, hit, pop;
    logic [31:0] want;
    acc = req_valid_i & req_ready_o;
    hit = req_o & gnt_i;
    pop = resp_valid_o & resp_ready_i;
    if (hit) grant_cnt++;
    if (pop) begin
      if (exp_q.size() == 0) check_output("sb_underrun", exp_q.size(), 1);
      else begin
        want = exp_q.pop_front();
        check_output("resp_data", resp_rdata_o, want);
      end
    end
    @(posedge clk_i);
    #1;
    if (acc) begin
      to_send--;
      req_add_i++;
      req_wdata_i++;
    end
    req_valid_i = (to_send > 0);
    if (net_auto) begin
      vld_i = hit;
      if (hit) begin
        rdata_i = 32'hD000_0000 + 32'(net_seq);
        net_seq++;
        exp_q.push_back(rdata_i);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      sample();
      apply_stimulus();
    end
  endtask

  task automatic issue(input int n, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    to_send     = n;
    req_wen_i   = w;
    req_add_i   = a;
    req_wdata_i = d;
    req_valid_i = 1'b1;
  endtask

  task automatic check_reset_values(input string pfx);
    check_output({pfx, "_req_o"}, req_o, 0);
    check_output({pfx, "_resp_valid"}, resp_valid_o, 0);
    check_output({pfx, "_req_ready"}, req_ready_o, 1);
    check_output({pfx, "_add_o"}, add_o, 0);
    check_output({pfx, "_wen_o"}, wen_o, 0);
    check_output({pfx, "_wdata_o"}, wdata_o, 0);
    check_output({pfx, "_resp_rdata"}, resp_rdata_o, 0);
    check_output({pfx, "_cnt"}, dut.cnt_q, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int acc_n, grants_n;
    bit saw_resp_n, cnt_nz_n;

    rst_i = 1'b1;
    req_valid_i = 0; req_wen_i = 0; req_add_i = '0; req_wdata_i = '0;
    resp_ready_i = 0; gnt_i = 0; vld_i = 0; rdata_i = '0;
    req_valid_n = 0; req_wen_n = 0; req_add_n = '0; req_wdata_n = '0;
    resp_ready_n = 0; gnt_n = 0; vld_n = 0; rdata_n = '0;

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    sample();
    check_output("in_rst_req_o", req_o, 0);
    check_output("in_rst_resp_valid", resp_valid_o, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    sample();
    check_reset_values("por");
    apply_stimulus();

    // Single load: accept, grant next cycle, response one cycle later
    issue(1, 1'b0, 5'd5, 32'h0);
    sample();
    check_output("t1_ready_c0", req_ready_o, 1);
    check_output("t1_req_c0", req_o, 0);
    apply_stimulus();
    gnt_i = 1'b1;
    sample();
    check_output("t1_req_c1", req_o, 1);
    check_output("t1_add_c1", add_o, 5);
    check_output("t1_wen_c1", wen_o, 0);
    check_output("t1_ready_c1", req_ready_o, 1);
    apply_stimulus();
    gnt_i = 1'b0; vld_i = 1'b1; rdata_i = 32'hCAFE0001;
    exp_q.push_back(32'hCAFE0001);
    sample();
    check_output("t1_req_c2", req_o, 0);
    check_output("t1_rvalid_c2", resp_valid_o, 0);
    apply_stimulus();
    vld_i = 1'b0; resp_ready_i = 1'b1;
    sample();
    check_output("t1_rvalid_c3", resp_valid_o, 1);
    check_output("t1_rdata_c3", resp_rdata_o, 32'hCAFE0001);
    apply_stimulus();
    resp_ready_i = 1'b0;
    sample();
    check_output("t1_rvalid_c4", resp_valid_o, 0);
    check_output("t1_rdata_hold", resp_rdata_o, 32'hCAFE0001);
    apply_stimulus();

    // Conflict hold: three denied cycles then a grant
    net_auto = 1'b1;
    issue(1, 1'b1, 5'd9, 32'h12345678);
    sample();
    check_output("t2_ready_load", req_ready_o, 1);
    apply_stimulus();
    for (int k = 0; k < 3; k++) begin
      sample();
      check_output("t2_req_held", req_o, 1);
      check_output("t2_add_held", add_o, 9);
      check_output("t2_wdata_held", wdata_o, 32'h12345678);
      check_output("t2_ready_low", req_ready_o, 0);
      apply_stimulus();
    end
    gnt_i = 1'b1;
    sample();
    check_output("t2_add_gnt", add_o, 9);
    check_output("t2_wdata_gnt", wdata_o, 32'h12345678);
    check_output("t2_wen_gnt", wen_o, 1);
    check_output("t2_ready_gnt", req_ready_o, 1);
    apply_stimulus();
    gnt_i = 1'b0;
    sample();
    check_output("t2_req_done", req_o, 0);
`ifdef TCDM_SHIM_STATS_EN
    check_output("t2_stall_cnt", stall_cnt, 3);
`endif
    apply_stimulus();
    resp_ready_i = 1'b1;
    sample();
    check_output("t2_wresp_valid", resp_valid_o, 1);
    apply_stimulus();
    resp_ready_i = 1'b0;
    sample();
    check_output("t2_drained", resp_valid_o, 0);
    check_output("t2_sb_empty", exp_q.size(), 0);
    apply_stimulus();

    // Full FIFO: four queued responses, then push 5 while popping 1
    net_auto = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vld_i = 1'b1;
      rdata_i = 32'(i + 1);
      exp_q.push_back(rdata_i);
      sample();
      apply_stimulus();
    end
    vld_i = 1'b0;
    sample();
    check_output("t4_full", dut.fifo_cnt_q, 4);
    check_output("t4_head", resp_rdata_o, 1);
    apply_stimulus();
    vld_i = 1'b1; rdata_i = 32'd5; exp_q.push_back(32'd5); resp_ready_i = 1'b1;
    sample();
    apply_stimulus();
    vld_i = 1'b0;
    run(4);
    resp_ready_i = 1'b0;
    sample();
    check_output("t4_empty", resp_valid_o, 0);
    check_output("t4_sb_empty", exp_q.size(), 0);
    check_output("t4_last_hold", resp_rdata_o, 5);
    apply_stimulus();

    // Credit limit: six loads, no pops
    net_auto = 1'b1;
    grant_cnt = 0;
    gnt_i = 1'b1;
    issue(6, 1'b0, 5'd0, 32'h0);
    run(8);
    sample();
    check_output("t3_grants4", grant_cnt, 4);
    check_output("t3_req_low", req_o, 0);
    check_output("t3_ready_low", req_ready_o, 0);
    check_output("t3_cnt4", dut.cnt_q, 4);
    check_output("t3_rvalid", resp_valid_o, 1);
    apply_stimulus();
    resp_ready_i = 1'b1;
    sample();
    apply_stimulus();
    resp_ready_i = 1'b0;
    run(2);
    sample();
    check_output("t3_grant5", grant_cnt, 5);
    check_output("t3_req_low2", req_o, 0);
    apply_stimulus();
    resp_ready_i = 1'b1;
    run(14);
    sample();
    check_output("t3_grants6", grant_cnt, 6);
    check_output("t3_sb_empty", exp_q.size(), 0);
    check_output("t3_rvalid_end", resp_valid_o, 0);
    check_output("t3_cnt_end", dut.cnt_q, 0);
    apply_stimulus();
    gnt_i = 1'b0; resp_ready_i = 1'b0; net_auto = 1'b0;

    // Write credits on the WriteRespOn=0 instance
    acc_n = 0; grants_n = 0; saw_resp_n = 0; cnt_nz_n = 0;
    req_wen_n = 1'b1; gnt_n = 1'b1; resp_ready_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      req_valid_n = (acc_n < 8);
      req_add_n = AW'(i);
      req_wdata_n = 32'hF000_0000 + 32'(i);
      @(negedge clk_i);
      if (req_valid_n && req_ready_n) acc_n++;
      if (req_o_n && gnt_n) grants_n++;
      if (resp_valid_n) saw_resp_n = 1'b1;
      if (dut_nw.cnt_q != 0) cnt_nz_n = 1'b1;
      if (i == 7) check_output("t5_back_to_back", acc_n, 8);
      @(posedge clk_i);
      #1;
    end
    req_valid_n = 1'b0; gnt_n = 1'b0;
    check_output("t5_grants", grants_n, 8);
    check_output("t5_cnt_nz", cnt_nz_n, 0);
    check_output("t5_resp_seen", saw_resp_n, 0);
    check_output("t5_cnt_end", dut_nw.cnt_q, 0);

    // Reset mid-flight with vld_i high during reset
    gnt_i = 1'b1;
    issue(3, 1'b0, 5'h1A, 32'hA5A50000);
    run(2);
    vld_i = 1'b1; rdata_i = 32'hBEEF0001;
    sample();
    apply_stimulus();
    rst_i = 1'b1; vld_i = 1'b1; rdata_i = 32'hBEEF0002; gnt_i = 1'b0;
    sample();
    check_output("t6_cnt_pre", dut.cnt_q, 2);
    check_output("t6_rvalid_pre", resp_valid_o, 1);
    check_output("t6_req_pre", req_o, 1);
    apply_stimulus();
    to_send = 0; req_valid_i = 1'b0; exp_q.delete();
    rst_i = 1'b0; vld_i = 1'b0;
    sample();
    check_reset_values("mid_rst");
    apply_stimulus();
    sample();
    check_output("t6_rvalid_post", resp_valid_o, 0);
    check_output("t6_fifo_empty", dut.fifo_cnt_q, 0);
    apply_stimulus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
